// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common mouse command
// bytes and the odd-parity helper used for the frame parity bit.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_CLK,
        SHIFT,
        ACK,
        RELEASE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // Odd parity: the parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin plus a falling-edge
// detect on the synchronised value. Also used by the PS/2 receiver.
//   clk      system clock
//   reset    asynchronous active-low reset
//   pin_i    raw pin value
//   sync_o   synchronised pin value
//   fe_o     one-cycle pulse on a synchronised 1 -> 0 transition
module ps2_sync_edge #(
    parameter logic RESET_VAL = 1'b1   // idle bus level, so reset creates no edge
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic sync_o,
    output logic fe_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fe_o   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop bit, then the device ACK. Lines are driven as
// open-drain enables (1 = pull low).
//   clk          system clock
//   reset        asynchronous active-low reset
//   send         request strobe, accepted only while idle
//   tx_byte      command byte, captured on the accepting cycle
//   ps2_clk_in   raw PS2_CLK pin
//   ps2_dat_in   raw PS2_DAT pin
//   ps2_clk_oe   1 = pull PS2_CLK low
//   ps2_dat_oe   1 = pull PS2_DAT low
//   busy         transmission in progress
//   done         1-cycle pulse: frame sent and ACK seen
//   error        1-cycle pulse: timeout or NACK
//
// state    | meaning
// IDLE     | lines released, waiting for send
// INHIBIT  | clock held low to abort any device traffic
// RTS      | clock and data low (start bit) before clock release
// WAIT_CLK | clock released, waiting for the first device falling edge
// SHIFT    | driving data/parity/stop bits on device falling edges
// ACK      | waiting for the falling edge that carries the device ACK
// RELEASE  | waiting for both lines to return high
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int INHIBIT_US       = 120,
    parameter int RTS_US           = 2,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] tx_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int INH_CYC    = CYC_PER_US * INHIBIT_US;
    localparam int RTS_CYC    = CYC_PER_US * RTS_US;
    localparam int START_CYC  = CYC_PER_US * START_TIMEOUT_US;
    localparam int FRAME_CYC  = CYC_PER_US * FRAME_TIMEOUT_US;
    localparam int TMR_MAX    = (START_CYC > INH_CYC) ?
                                ((START_CYC > RTS_CYC) ? START_CYC : RTS_CYC) :
                                ((INH_CYC > RTS_CYC) ? INH_CYC : RTS_CYC);
    localparam int TW         = $clog2(TMR_MAX + 1);
    localparam int FW         = $clog2(FRAME_CYC + 1);

    ps2_tx_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [8:0]    shift_q, shift_d;     // {parity, data}, shifted out LSB first
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          ack_ok_q, ack_ok_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          fail;

    logic clk_sync, clk_fe, dat_sync, dat_fe_unused;

    ps2_sync_edge u_sync_clk (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (ps2_clk_in),
        .sync_o (clk_sync),
        .fe_o   (clk_fe)
    );

    ps2_sync_edge u_sync_dat (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (ps2_dat_in),
        .sync_o (dat_sync),
        .fe_o   (dat_fe_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            frame_q  <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            ack_ok_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            frame_q  <= frame_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            ack_ok_q <= ack_ok_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        frame_d  = frame_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        ack_ok_d = ack_ok_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        fail     = 1'b0;

        unique case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                // A send coinciding with the done/error pulse belongs to the
                // frame that just ended and is dropped.
                if (send && !done_q && !error_q) begin
                    shift_d = {odd_parity(tx_byte), tx_byte};
                    timer_d = TW'(INH_CYC - 1);
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == '0) begin
                    timer_d  = TW'(RTS_CYC - 1);
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RTS: begin
                if (timer_q == '0) begin
                    timer_d = TW'(START_CYC - 1);
                    state_d = WAIT_CLK;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            WAIT_CLK: begin
                if (clk_fe) begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    bitcnt_d = 4'd1;
                    frame_d  = FW'(FRAME_CYC - 1);
                    state_d  = SHIFT;
                end else if (timer_q == '0) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SHIFT: begin
                if (frame_q == '0) begin
                    fail = 1'b1;
                end else begin
                    frame_d = frame_q - FW'(1);
                    if (clk_fe) begin
                        // bitcnt 1..8 drive data bits 1..7 then parity; 9 drives stop.
                        if (bitcnt_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end else begin
                            dat_oe_d = ~shift_q[0];
                            shift_d  = {1'b0, shift_q[8:1]};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
            end
            ACK: begin
                if (frame_q == '0) begin
                    fail = 1'b1;
                end else begin
                    frame_d = frame_q - FW'(1);
                    if (clk_fe) begin
                        ack_ok_d = ~dat_sync;
                        state_d  = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (frame_q == '0) begin
                    fail = 1'b1;
                end else begin
                    frame_d = frame_q - FW'(1);
                    if (clk_sync && dat_sync) begin
                        done_d  = ack_ok_q;
                        error_d = ~ack_ok_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            state_d  = IDLE;
            dat_oe_d = 1'b0;
            error_d  = 1'b1;
        end
    end

    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule
